vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: horizontal active, front porch, sync and back porch lengths in pixels.
REQ-002 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: vertical active, front porch, sync and back porch lengths in lines.
REQ-003 SHALL have parameters HS_ACT=1 and VS_ACT=1: the asserted level of hsync and vsync.
REQ-004 SHALL have parameter CNT_W=10, the width of the address outputs.
REQ-005 SHALL have parameter LEAD=2 (legal range 0..7), the number of pixel periods by which fetch outputs lead display outputs.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ce  in  1  pixel enable; the block advances only on clk edges where ce=1.
REQ-009 fetch_h, fetch_v  out  CNT_W each  current horizontal and vertical counter values (lead stage).
REQ-010 fetch_valid  out  1  high when fetch_h<H_ACTIVE and fetch_v<V_ACTIVE.
REQ-011 h_addr, v_addr  out  CNT_W each  display-stage addresses.
REQ-012 valid  out  1  display-stage addressable-video flag.
REQ-013 hsync, vsync  out  1 each  display-stage sync outputs at the configured polarity.
REQ-014 line_start  out  1  high while h_addr==0 at the display stage.
REQ-015 frame_start  out  1  high while h_addr==0 and v_addr==0 at the display stage.

Function
REQ-016 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; elaboration SHALL fail if either H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or if LEAD>7.
REQ-017 On a ce=1 edge the h counter SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-018 The v counter SHALL increment only on the edge where h wraps, wrapping from V_TOTAL-1 to 0; a simultaneous h/v wrap SHALL yield h=0 and v=0.
REQ-019 fetch_valid SHALL be decoded from the counter registers in the same cycle as fetch_h and fetch_v.
REQ-020 The display stage SHALL be a LEAD-deep pipeline of {addresses, valid, hsync, vsync} that shifts only on ce=1 edges; with LEAD=0 the display outputs SHALL equal the fetch-stage values.
REQ-021 Sync decode SHALL hold hsync at the HS_ACT level for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and at the opposite level otherwise; vsync SHALL follow the same rule on v with V_* and VS_ACT.
REQ-022 When ce=0 every register SHALL hold its value.
REQ-023 line_start and frame_start SHALL be decoded from the display-stage registers and last one pixel period each.

Reset
REQ-024 While reset=1, the counters, fetch_h, fetch_v, h_addr and v_addr SHALL be 0; fetch_valid SHALL be 1; valid SHALL be 0; hsync SHALL be ~HS_ACT and vsync ~VS_ACT; line_start and frame_start SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL take effect immediately, independent of clk and ce.
REQ-026 For the first LEAD ce edges after reset release, the display stage SHALL present pipeline-fill values that keep valid=0 and both syncs inactive.

Configuration
REQ-027 Macro VGA_TIMING_FRAME_CNT_EN defined: the block SHALL add output frame_cnt [7:0] that increments on each display-stage transition into (0,0), wraps 255->0 and resets to 0.
REQ-028 Macro VGA_TIMING_FRAME_CNT_EN undefined: the frame_cnt port and its logic SHALL be absent.

Verification
REQ-029 Defaults, ce=1, release reset: fetch_h=0,1,2 on successive cycles; h_addr=0 with valid=1 two cycles after release; line_start and frame_start are high in that cycle.
REQ-030 Defaults, ce=1: hsync is high exactly for h_addr 656..751 (96 clk); fetch_h goes 799->0 with fetch_v +1; frame period is 420000 clk.
REQ-031 Defaults: vsync is high for v_addr 490..491 (1600 clk); v 524->0 coincides with h 799->0.
REQ-032 ce toggling 1,0,1,0: outputs change only on ce=1 edges; frame period is 840000 clk.
REQ-033 Assert reset asynchronously at fetch_h=300, fetch_v=200: all outputs take their REQ-024 values before the next clk edge.
REQ-034 With VGA_TIMING_FRAME_CNT_EN defined, run 256 frames: frame_cnt goes 0..255 then 0, stepping with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: fetch-stage counters plus a LEAD-deep display pipeline.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_ACT   = 1'b1,
  parameter logic VS_ACT   = 1'b1,
  parameter int   CNT_W    = 10,
  parameter int   LEAD     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic [CNT_W-1:0] fetch_h,
  output logic [CNT_W-1:0] fetch_v,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] h_addr,
  output logic [CNT_W-1:0] v_addr,
  output logic             valid,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (longint'(H_TOTAL) - 1 > CNT_MAX) begin : g_h_range
    $error("H_TOTAL-1 does not fit in CNT_W bits");
  end
  if (longint'(V_TOTAL) - 1 > CNT_MAX) begin : g_v_range
    $error("V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (LEAD > 7 || LEAD < 0) begin : g_lead_range
    $error("LEAD must be in 0..7");
  end

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             f_vld;
  logic             f_hs;
  logic             f_vs;

  logic [CNT_W-1:0] d_h;
  logic [CNT_W-1:0] d_v;
  logic             d_vld;
  logic             d_hs;
  logic             d_vs;
  logic             d_ok;

  // Raster counters: h wraps at line end, v steps only on that wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + ONE;
        end
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  // Fetch-stage decode straight from the counter registers.
  always_comb begin
    f_vld = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    f_hs  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    f_vs  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  end

  assign fetch_h     = h_cnt;
  assign fetch_v     = v_cnt;
  assign fetch_valid = f_vld;

  if (LEAD == 0) begin : g_direct
    // No lead: display mirrors fetch, but stays blank while in reset.
    always_comb begin
      d_h   = h_cnt;
      d_v   = v_cnt;
      d_vld = f_vld & ~reset;
      d_hs  = f_hs & ~reset;
      d_vs  = f_vs & ~reset;
      d_ok  = ~reset;
    end
  end else begin : g_pipe
    logic [CNT_W-1:0] p_h   [LEAD];
    logic [CNT_W-1:0] p_v   [LEAD];
    logic             p_vld [LEAD];
    logic             p_hs  [LEAD];
    logic             p_vs  [LEAD];
    logic             p_ok  [LEAD];

    // Delay line; p_ok marks entries that carry real raster positions.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LEAD; i++) begin
          p_h[i]   <= '0;
          p_v[i]   <= '0;
          p_vld[i] <= 1'b0;
          p_hs[i]  <= 1'b0;
          p_vs[i]  <= 1'b0;
          p_ok[i]  <= 1'b0;
        end
      end else if (ce) begin
        p_h[0]   <= h_cnt;
        p_v[0]   <= v_cnt;
        p_vld[0] <= f_vld;
        p_hs[0]  <= f_hs;
        p_vs[0]  <= f_vs;
        p_ok[0]  <= 1'b1;
        for (int i = 1; i < LEAD; i++) begin
          p_h[i]   <= p_h[i-1];
          p_v[i]   <= p_v[i-1];
          p_vld[i] <= p_vld[i-1];
          p_hs[i]  <= p_hs[i-1];
          p_vs[i]  <= p_vs[i-1];
          p_ok[i]  <= p_ok[i-1];
        end
      end
    end

    // Display stage is the last pipeline entry.
    always_comb begin
      d_h   = p_h[LEAD-1];
      d_v   = p_v[LEAD-1];
      d_vld = p_vld[LEAD-1];
      d_hs  = p_hs[LEAD-1];
      d_vs  = p_vs[LEAD-1];
      d_ok  = p_ok[LEAD-1];
    end
  end

  // Display outputs with sync polarity applied.
  always_comb begin
    h_addr      = d_h;
    v_addr      = d_v;
    valid       = d_vld;
    hsync       = d_hs ? HS_ACT : ~HS_ACT;
    vsync       = d_vs ? VS_ACT : ~VS_ACT;
    line_start  = d_ok && (d_h == '0);
    frame_start = d_ok && (d_h == '0) && (d_v == '0);
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fc;

  // Step when the display stage leaves the last pixel of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc <= 8'd0;
    end else if (ce && d_ok && d_h == H_LAST && d_v == V_LAST) begin
      fc <= fc + 8'd1;
    end
  end

  assign frame_cnt = fc;
`endif

endmodule
